vector_stream_loader: RTL

VECTOR_STREAM_LOADER -- requirements
Module: vector_stream_loader

---
 rtl/vector_stream_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/vector_stream_loader.sv
// Collects a signed element stream into a zeroed vector buffer, then hands it to a
// reduce ALU with a one-cycle start pulse and waits for the ALU to report done.
module vector_stream_loader #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [BITS-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic signed [BITS-1:0] out_vec [N-1:0],
    output logic        [BITS-1:0] out_len,
    output logic                   start,
    input  logic                   alu_done,
    output logic                   busy,
    output logic        [15:0]     vec_count,
    output logic        [1:0]      fsm_state
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;
    logic          last_beat;

    // Handshake: an element moves only on a cycle where in_valid && in_ready;
    // otherwise the producer keeps in_data/in_last stable and retries.
    assign accept    = in_valid && in_ready;
    assign last_beat = in_last || (count == CW'(N - 1));
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            count     <= '0;
            out_len   <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            vec_count <= '0;
            for (int i = 0; i < N; i++) begin
                out_vec[i] <= '0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    // in_ready comes up one edge after reset release, then stays up in FILL
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_vec[count[IW-1:0]] <= in_data;
                        count                  <= count + CW'(1);
                        if (last_beat) begin
                            state    <= S_ISSUE;
                            start    <= 1'b1;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                            out_len  <= BITS'(count + CW'(1));
                        end
                    end
                end
                S_ISSUE: begin
                    start <= 1'b0;
                    state <= S_GUARD;
                end
                S_GUARD: begin
                    // a done level left over from the previous operation is ignored here
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        state     <= S_FILL;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        count     <= '0;
                        vec_count <= vec_count + 16'd1;
                        for (int i = 0; i < N; i++) begin
                            out_vec[i] <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule
